// File: rtl/shared_pkg.sv
// Shared types and constants for the SPI command master.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: spi_cmd_e command encoding, master_state_e FSM states,
//           frame/receive bit counts and the TX frame packing helper.
package shared_pkg;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } spi_cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    WAIT,
    SAMPLE,
    GAP
  } master_state_e;

  localparam int FRAME_BITS = 11;
  localparam int RX_BITS    = 8;

  // On-wire frame: read/write select sent twice, then cmd[0], then payload MSB first.
  function automatic logic [FRAME_BITS-1:0] tx_word(input logic [1:0] cmd, input logic [7:0] dat);
    return {cmd[1], cmd[1], cmd[0], dat};
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Request/response bundle between a command source and spi_master.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready handshake; rsp_valid is a one-cycle pulse, no ready.
// Modports: master = command source, slave = the spi_master block.
interface spi_master_if;

  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_cmd;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;

  modport master (
    output req_valid, req_cmd, req_data,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_cmd, req_data,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/spi_master_shifter.sv
// TX parallel-load shift register and RX serial-in shift register.
// Latency: TX MSB visible the cycle after load/shift; rx_nxt is the RX value after the current edge.
// Backpressure: none; enables come from the owning FSM.
// Ports: clk, rst_n; tx_load/tx_load_dat/tx_shift -> tx_msb; rx_shift/rx_in -> rx_nxt.
module spi_master_shifter
  import shared_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_load,
  input  logic [FRAME_BITS-1:0] tx_load_dat,
  input  logic                  tx_shift,
  output logic                  tx_msb,
  input  logic                  rx_shift,
  input  logic                  rx_in,
  output logic [RX_BITS-1:0]    rx_nxt
);

  logic [FRAME_BITS-1:0] tx_q;
  logic [RX_BITS-1:0]    rx_q;

  assign tx_msb = tx_q[FRAME_BITS-1];
  // Exposed so the owner can capture the full byte on the same edge as the last sample.
  assign rx_nxt = {rx_q[RX_BITS-2:0], rx_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      if (tx_load) begin
        tx_q <= tx_load_dat;
      end else if (tx_shift) begin
        tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};
      end
      if (rx_shift) begin
        rx_q <= rx_nxt;
      end
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI command master: one request -> one framed SPI transaction, optional read-back byte.
// Latency: SS_n falls the cycle after accept; read byte presented in the cycle SS_n rises.
// Backpressure: req_ready high only when idle; responses are unthrottled one-cycle pulses.
// Ports: clk, rst_n (async, active low); req_if (slave modport); busy, SS_n, MOSI, MISO.
// Build option SPI_MASTER_STATS_EN adds frame_cnt and rd_cnt counters/ports.
module spi_master
  import shared_pkg::*;
#(
  parameter int RD_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  spi_master_if.slave req_if,
  output logic        busy,
  output logic        SS_n,
  output logic        MOSI,
  input  logic        MISO
`ifdef SPI_MASTER_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] rd_cnt
`endif
);

  master_state_e      state, state_nxt;
  logic [3:0]         bit_cnt, cnt_load;
  spi_cmd_e           cmd_q;
  logic               ready_q, rsp_valid_q;
  logic [7:0]         rsp_data_q;
  logic               tx_msb;
  logic [RX_BITS-1:0] rx_nxt;
  logic               accept, cnt_done, rsp_done;

  assign accept   = (state == IDLE) && ready_q && req_if.req_valid;
  assign cnt_done = (bit_cnt == 4'd0);
  assign rsp_done = (state == SAMPLE) && (state_nxt == GAP);

  assign req_if.req_ready = ready_q;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_data  = rsp_data_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = START;
      START:   state_nxt = SHIFT;
      SHIFT:   if (cnt_done) state_nxt = (cmd_q == RD_DATA) ? WAIT : GAP;
      WAIT:    if (cnt_done) state_nxt = SAMPLE;
      SAMPLE:  if (cnt_done) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter holds "remaining cycles after this one" for the state being entered.
  always_comb begin
    cnt_load = 4'd0;
    case (state_nxt)
      SHIFT:   cnt_load = 4'(FRAME_BITS - 1);
      WAIT:    cnt_load = 4'(RD_WAIT - 1);
      SAMPLE:  cnt_load = 4'(RX_BITS - 1);
      default: cnt_load = 4'd0;
    endcase
  end

  // Outputs are registered from the next state so each one is valid for the whole cycle it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= 4'd0;
      cmd_q       <= WR_ADDR;
      ready_q     <= 1'b0;
      busy        <= 1'b0;
      SS_n        <= 1'b1;
      MOSI        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        bit_cnt <= cnt_load;
      end else if (!cnt_done) begin
        bit_cnt <= bit_cnt - 4'd1;
      end
      if (accept) begin
        cmd_q <= spi_cmd_e'(req_if.req_cmd);
      end
      ready_q     <= (state_nxt == IDLE);
      busy        <= (state_nxt != IDLE);
      SS_n        <= !(state_nxt inside {START, SHIFT, WAIT, SAMPLE});
      MOSI        <= (state_nxt == SHIFT) ? tx_msb : 1'b0;
      rsp_valid_q <= rsp_done;
      if (rsp_done) begin
        rsp_data_q <= rx_nxt;
      end
    end
  end

  spi_master_shifter u_shifter (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_load     (accept),
    .tx_load_dat (tx_word(req_if.req_cmd, req_if.req_data)),
    .tx_shift    (state_nxt == SHIFT),
    .tx_msb      (tx_msb),
    .rx_shift    (state == SAMPLE),
    .rx_in       (MISO),
    .rx_nxt      (rx_nxt)
  );

`ifdef SPI_MASTER_STATS_EN
  // Counted on the edge that ends GAP; rsp_valid is high throughout a read frame's GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 16'h0000;
      rd_cnt    <= 16'h0000;
    end else if (state == GAP) begin
      frame_cnt <= frame_cnt + 16'd1;
      if (rsp_valid_q) begin
        rd_cnt <= rd_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_master.sv
// Randomized scoreboard bench for spi_master with a behavioural SPI slave.
// Stimulus pushes expected frames; a monitor decodes SS_n/MOSI, drives MISO and checks responses.
module tb_spi_master;

  localparam int RD_W = 3;

  typedef struct packed {
    logic [1:0] cmd;
    logic [7:0] dat;
    logic [7:0] rsp;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n;
  logic busy, SS_n, MOSI, MISO;
`ifdef SPI_MASTER_STATS_EN
  logic [15:0] frame_cnt, rd_cnt;
`endif

  spi_master_if bus ();

  spi_master #(.RD_WAIT(RD_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_if (bus),
    .busy   (busy),
    .SS_n   (SS_n),
    .MOSI   (MOSI),
    .MISO   (MISO)
`ifdef SPI_MASTER_STATS_EN
    ,
    .frame_cnt (frame_cnt),
    .rd_cnt    (rd_cnt)
`endif
  );

  always #5 clk = ~clk;

  int     vectors = 0;
  int     miscompares = 0;
  frame_t sb[$];
  logic [7:0] s_mem [256];
  logic [7:0] s_addr;
  logic   in_frame = 1'b0;
  int     both_viol = 0;
  int     high_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave model: address register plus byte memory; computes the read-back at issue time.
  task automatic model_push(input logic [1:0] c, input logic [7:0] d);
    frame_t f;
    f.cmd = c;
    f.dat = d;
    f.rsp = 8'h00;
    case (c)
      2'b00, 2'b10: s_addr = d;
      2'b01:        s_mem[s_addr] = d;
      default:      f.rsp = s_mem[s_addr];
    endcase
    sb.push_back(f);
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_cmd   = c;
    bus.req_data  = d;
    while (!bus.req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("accept", 32'(bus.req_ready), 32'd1);
    if (bus.req_ready) model_push(c, d);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || in_frame || busy) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("idle_reached", 32'(t < 2000), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ss_n"},      32'(SS_n), 32'd1);
    check({tag, "_mosi"},      32'(MOSI), 32'd0);
    check({tag, "_busy"},      32'(busy), 32'd0);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_data"},  32'(bus.rsp_data), 32'd0);
  endtask

  // Monitor / slave: samples at negedge, drives MISO for the following rising edge.
  initial begin : monitor
    frame_t cur;
    logic   prev_ss = 1'b1;
    logic   is_gap;
    logic   e;
    int     k = 0, j, mosi_err = 0, stray = 0, high_cnt = 100, exp_len;
    cur  = '0;
    MISO = 1'b0;
    forever begin
      @(negedge clk);
      is_gap = 1'b0;
      if (!rst_n) begin
        in_frame = 1'b0;
        prev_ss  = 1'b1;
        high_cnt = 100;
        MISO     = 1'($urandom);
        continue;
      end
      if (busy && bus.req_ready) both_viol++;
      if (in_frame && SS_n) begin
        is_gap  = 1'b1;
        exp_len = (cur.cmd == 2'b11) ? 12 + RD_W + 8 : 12;
        check("frame_len", 32'(k), 32'(exp_len));
        check("mosi_bits", 32'(mosi_err), 32'd0);
        check("rsp_stray_in_frame", 32'(stray), 32'd0);
        check("rsp_valid_at_rise", 32'(bus.rsp_valid), 32'(cur.cmd == 2'b11));
        if (cur.cmd == 2'b11) check("rsp_data", 32'(bus.rsp_data), 32'(cur.rsp));
        in_frame = 1'b0;
        high_cnt = 0;
      end
      if (prev_ss && !SS_n) begin
        check("frame_expected", 32'(sb.size() > 0), 32'd1);
        check("ss_high_gap", 32'(high_cnt >= 2), 32'd1);
        if (sb.size() > 0) begin
          cur      = sb.pop_front();
          in_frame = 1'b1;
          k        = 0;
          mosi_err = 0;
          stray    = 0;
        end
      end
      if (in_frame && !SS_n) begin
        e = 1'b0;
        if (k == 1 || k == 2) e = cur.cmd[1];
        else if (k == 3) e = cur.cmd[0];
        else if (k >= 4 && k <= 11) e = cur.dat[11-k];
        if (MOSI !== e) mosi_err++;
        if (bus.rsp_valid) stray++;
        j = k - (12 + RD_W);
        if (cur.cmd == 2'b11 && j >= 0 && j < 8) MISO = cur.rsp[7-j];
        else MISO = 1'($urandom);
        k++;
      end else begin
        MISO = 1'($urandom);
      end
      if (SS_n) begin
        if (MOSI !== 1'b0) high_err++;
        if (!is_gap && bus.rsp_valid) high_err++;
        high_cnt++;
      end
      prev_ss = SS_n;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    int accepts;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_cmd   = 2'b00;
    bus.req_data  = 8'h00;
    for (int i = 0; i < 256; i++) s_mem[i] = 8'($urandom);
    s_mem[8'hA5] = 8'h5A;
    s_addr       = 8'h00;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(bus.req_ready), 32'd1);

    // Single write-address frame, then address/read-back against a preloaded byte.
    send(2'b00, 8'h3C);
    send(2'b10, 8'hA5);
    send(2'b11, 8'h00);
    wait_idle();

    // Request held continuously: one accept per frame.
    accepts = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_cmd   = 2'b01;
      bus.req_data  = 8'hFF;
      if (bus.req_ready) begin
        model_push(2'b01, 8'hFF);
        accepts++;
      end
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("hold_accepts", 32'(accepts >= 2), 32'd1);
    wait_idle();

    for (int i = 0; i < 20; i++) send(2'($urandom_range(0, 3)), 8'($urandom));
    wait_idle();

    // Known byte 0x9B (MISO 1,0,0,1,1,0,1,1).
    send(2'b00, 8'h40);
    send(2'b01, 8'h9B);
    send(2'b10, 8'h40);
    send(2'b11, 8'h00);
    wait_idle();

    // Reset in the middle of the SHIFT phase of a read-data frame.
    send(2'b11, 8'h00);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_abort", 32'(bus.req_ready), 32'd1);
`ifdef SPI_MASTER_STATS_EN
    check("frame_cnt_reset", 32'(frame_cnt), 32'd0);
    check("rd_cnt_reset", 32'(rd_cnt), 32'd0);
`endif
    send(2'b00, 8'h21);
    send(2'b01, 8'h77);
    send(2'b01, 8'h78);
    send(2'b11, 8'h00);
    send(2'b11, 8'h00);
    wait_idle();
`ifdef SPI_MASTER_STATS_EN
    check("frame_cnt", 32'(frame_cnt), 32'd5);
    check("rd_cnt", 32'(rd_cnt), 32'd2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("frame_cnt_clear", 32'(frame_cnt), 32'd0);
    check("rd_cnt_clear", 32'(rd_cnt), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
`endif

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("busy_ready_exclusive", 32'(both_viol), 32'd0);
    check("idle_outputs_quiet", 32'(high_err), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
